// File: rtl/oled_pkg.sv
// Shared types and constants for the OLED field-write arbiter.
package oled_pkg;

  // Controller states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARB   = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_NEXT  = 3'd4,
    ST_FIN   = 3'd5
  } state_e;

  // Requester indices (bit positions in req/grant/done).
  localparam int unsigned N_REQ     = 4;
  localparam logic [1:0]  REQ_PRICE = 2'd0;
  localparam logic [1:0]  REQ_CENTS = 2'd1;
  localparam logic [1:0]  REQ_COINS = 2'd2;
  localparam logic [1:0]  REQ_DISP  = 2'd3;

  // Default cycles allowed in WAIT before a char_done timeout.
  localparam int TMO_CYC = 255;

  // Field table: OLED row, first column and character count per requester.
  localparam logic [1:0] ROW_PRICE = 2'd0;
  localparam logic [3:0] COL_PRICE = 4'd0;
  localparam logic [3:0] LEN_PRICE = 4'd6;
  localparam logic [1:0] ROW_CENTS = 2'd1;
  localparam logic [3:0] COL_CENTS = 4'd0;
  localparam logic [3:0] LEN_CENTS = 4'd6;
  localparam logic [1:0] ROW_COINS = 2'd2;
  localparam logic [3:0] COL_COINS = 4'd0;
  localparam logic [3:0] LEN_COINS = 4'd6;
  localparam logic [1:0] ROW_DISP  = 2'd3;
  localparam logic [3:0] COL_DISP  = 4'd4;
  localparam logic [3:0] LEN_DISP  = 4'd8;

  typedef struct packed {
    logic [1:0] row;
    logic [3:0] col;
    logic [3:0] len;
  } field_t;

  // Field-table lookup by requester index.
  function automatic field_t field_lookup(input logic [1:0] id);
    field_t f;
    case (id)
      REQ_PRICE: f = '{row: ROW_PRICE, col: COL_PRICE, len: LEN_PRICE};
      REQ_CENTS: f = '{row: ROW_CENTS, col: COL_CENTS, len: LEN_CENTS};
      REQ_COINS: f = '{row: ROW_COINS, col: COL_COINS, len: LEN_COINS};
      default:   f = '{row: ROW_DISP,  col: COL_DISP,  len: LEN_DISP};
    endcase
    return f;
  endfunction

  // One-hot to index; a zero vector maps to index 0.
  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    if (oh[3])      idx = 2'd3;
    else if (oh[2]) idx = 2'd2;
    else if (oh[1]) idx = 2'd1;
    else            idx = 2'd0;
    return idx;
  endfunction

endpackage

// File: rtl/rr_arb4.sv
// Combinational 4-way round-robin pick, searching upward from last_grant+1.
module rr_arb4
  import oled_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last_grant,
  output logic [3:0] pick
);

  logic [1:0] cand;
  logic       found;

  // Scan the four positions starting just after the previous winner; the
  // previous winner itself is considered last.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= int'(N_REQ); i++) begin
      cand = 2'(last_grant + 2'(i));
      if (!found && req[cand]) begin
        pick[cand] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/oled_write_arbiter.sv
// Arbitrates four field writers onto one OLED character engine and
// sequences the per-character start/done handshake for the granted field.
module oled_write_arbiter
  import oled_pkg::*;
#(
  parameter int FIELD_W = 4,
  parameter int TMO_CYC = oled_pkg::TMO_CYC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FIELD_W-1:0] req,
  input  logic               clr,
  input  logic               char_done,
  output logic [FIELD_W-1:0] grant,
  output logic               char_start,
  output logic [1:0]         char_row,
  output logic [3:0]         char_col,
  output logic [FIELD_W-1:0] done,
  output logic               busy,
  output logic               err
);

  localparam int CNT_W = $clog2(TMO_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TMO_CYC);

  state_e           state_q, state_d;
  logic [3:0]       grant_q, grant_d;
  logic [3:0]       done_q, done_d;
  logic             char_start_q, char_start_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             armed_q, armed_d;
  logic [1:0]       row_q, row_d;
  logic [3:0]       col_q, col_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       last_q, last_d;

  logic [3:0]       pick;
  field_t           pick_fld;
  field_t           cur_fld;
  logic             last_char;

  rr_arb4 u_arb (
    .req        (req),
    .last_grant (last_q),
    .pick       (pick)
  );

  // Field parameters for the candidate winner and for the current owner.
  always_comb begin
    pick_fld  = field_lookup(onehot_to_idx(pick));
    cur_fld   = field_lookup(onehot_to_idx(grant_q));
    last_char = ({1'b0, idx_q} == (cur_fld.len - 4'd1));
  end

  // Next-state and next-output logic; pulses default low every cycle.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    row_d        = row_q;
    col_d        = col_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    done_d       = '0;
    char_start_d = 1'b0;
    err_d        = 1'b0;
    // armed_q delays leaving IDLE by one edge after reset release.
    armed_d      = 1'b1;

    if (clr) begin
      state_d = ST_IDLE;
      grant_d = '0;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (armed_q && (req != '0)) state_d = ST_ARB;
        end
        ST_ARB: begin
          if (req == '0) begin
            state_d = ST_IDLE;
            grant_d = '0;
          end else begin
            grant_d      = pick;
            row_d        = pick_fld.row;
            col_d        = pick_fld.col;
            idx_d        = '0;
            char_start_d = 1'b1;
            state_d      = ST_START;
          end
        end
        ST_START: begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          // A completion in the same cycle as the timeout takes precedence.
          if (char_done) begin
            state_d = last_char ? ST_FIN : ST_NEXT;
          end else if (cnt_q >= CNT_LAST) begin
            cnt_d   = CNT_FULL;
            err_d   = 1'b1;
            grant_d = '0;
            last_d  = onehot_to_idx(grant_q);
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_NEXT: begin
          col_d        = (col_q == 4'd15) ? 4'd15 : (col_q + 4'd1);
          idx_d        = idx_q + 3'd1;
          char_start_d = 1'b1;
          state_d      = ST_START;
        end
        ST_FIN: begin
          done_d  = grant_q;
          grant_d = '0;
          last_d  = onehot_to_idx(grant_q);
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  // All state and registered outputs; asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      done_q       <= '0;
      char_start_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      armed_q      <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      last_q       <= REQ_DISP;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      char_start_q <= char_start_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      armed_q      <= armed_d;
      row_q        <= row_d;
      col_q        <= col_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
    end
  end

  assign grant      = grant_q;
  assign done       = done_q;
  assign char_start = char_start_q;
  assign busy       = busy_q;
  assign err        = err_q;
  assign char_row   = row_q;
  assign char_col   = col_q;

endmodule

// File: doc/oled_write_arbiter.md
OLED_WRITE_ARBITER -- requirements
Module: oled_write_arbiter

Interface
REQ-001 The block SHALL have parameter FIELD_W, default 4, meaning the number of requesters (fixed at 4 in this revision).
REQ-002 The block SHALL have parameter TMO_CYC, default 255, meaning the cycles allowed in WAIT before a char_done timeout.
REQ-003 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; asynchronous and active-low.
REQ-005 req  input  4  level write requests, held until the matching done: bit0 price, bit1 cents, bit2 coins, bit3 disp.
REQ-006 clr  input  1  synchronous abort; active high.
REQ-007 char_done  input  1  one-cycle pulse from the character engine; the current character is complete.
REQ-008 grant  output  4  one-hot, registered; identifies the requester that owns the engine.
REQ-009 char_start  output  1  one-cycle pulse that launches one character write.
REQ-010 char_row  output  2  OLED row of the current character.
REQ-011 char_col  output  4  OLED column of the current character.
REQ-012 done  output  4  one-hot, one-cycle pulse; the granted field write has completed.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 err  output  1  one-cycle pulse on timeout.

Function
REQ-015 The FSM SHALL have states IDLE, ARB, START, WAIT, NEXT and FIN.
REQ-016 IDLE SHALL go to ARB when req is non-zero; otherwise it SHALL stay in IDLE.
REQ-017 ARB SHALL register grant by round-robin, searching from (last_grant+1) mod 4; last_grant SHALL reset to 3, so price wins first.
REQ-018 ARB SHALL load char_row and the start column from the field table for the granted requester and clear the character index, then go to START.
REQ-019 If req drops to zero during ARB, the block SHALL return to IDLE, grant SHALL go to 0 and no done SHALL be issued.
REQ-020 START SHALL assert char_start for exactly one cycle, then go to WAIT with the timeout counter cleared.
REQ-021 WAIT SHALL hold until char_done; char_done in any other state SHALL be ignored.
REQ-022 On char_done, if index equals len-1 the block SHALL go to FIN, otherwise to NEXT.
REQ-023 NEXT SHALL increment char_col and the index, then go to START, so char_start pulses are at least 3 cycles apart.
REQ-024 Field table (row, start column, length): price (0,0,6); cents (1,0,6); coins (2,0,6); disp (3,4,8).
REQ-025 char_col SHALL never exceed 15.
REQ-026 FIN SHALL pulse done equal to grant, clear grant, update last_grant, and return to IDLE.
REQ-027 A new grant SHALL be issued no earlier than 2 cycles after done.
REQ-028 The WAIT counter SHALL saturate at TMO_CYC; on reaching it the block SHALL pulse err, pulse no done, clear grant, update last_grant and go to IDLE.
REQ-029 clr SHALL force IDLE on the next edge from any state, clearing grant, index and counter, with no done and no err; clr SHALL take priority over char_done.
REQ-030 If char_done and the timeout occur in the same cycle, char_done SHALL win.
REQ-031 Requests arriving while busy SHALL wait for the next ARB; no requester SHALL be preempted.

Reset
REQ-032 While rst=0, the block SHALL force IDLE, grant=0, done=0, char_start=0, err=0, busy=0, char_row=0, char_col=0, counters=0 and last_grant=3.
REQ-033 The first ARB after reset SHALL occur no earlier than the second rising edge after rst rises.

Structure
REQ-034 Package oled_pkg SHALL hold the state enum, the requester index constants, the field-table constants (row, start column, length) and TMO_CYC.
REQ-035 Arbitration SHALL be implemented in sub-module rr_arb4 (inputs req and last_grant; output one-hot pick), which is purely combinational.
REQ-036 The FSM, counters and outputs SHALL be registered in oled_write_arbiter.

Verification
REQ-037 Bench scenario: req=0001, with char_done 2 cycles after each char_start -> 6 char_start pulses at row 0, cols 0..5, then done=0001 and busy low.
REQ-038 Bench scenario: req=1111 held -> grant order price, cents, coins, disp, price; disp writes at row 3, cols 4..11.
REQ-039 Bench scenario: req=0100 with char_done withheld -> err pulses 255 cycles after WAIT is entered, no done, grant=0.
REQ-040 Bench scenario: clr during the 3rd character of cents -> IDLE next cycle, no done, and a following req=0010 restarts at col 0.
REQ-041 Bench scenario: rst=0 asserted mid-WAIT -> all outputs 0 immediately, without waiting for a clock edge.
REQ-042 Bench scenario: char_done pulsed while in IDLE or START -> ignored, with no change in the index.
